// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, edge pulses,
// long-press detection and a press-toggled mode bit.
//
// state        | meaning
// -------------+----------------------------------------------------
// IDLE         | released, waiting for the synchronised level to rise
// PRESS_WAIT   | level high, counting stable cycles before accepting
// PRESSED      | press accepted, hold timer running toward long-press
// RELEASE_WAIT | level low, counting stable cycles before accepting
module btn_conditioner #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 100_000_000,
   parameter int unsigned ACTIVE_LOW      = 0,
   parameter int unsigned TOGGLE_INIT     = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic mode
);

   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

   // Timers count down to a terminal value; the load values place the
   // terminal compare on the same edge an up-count would reach N-1.
   localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
   localparam logic              INV       = (ACTIVE_LOW != 0);
   localparam logic              MODE_INIT = (TOGGLE_INIT != 0);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                s;
   logic [DEB_W-1:0]    deb_cnt, deb_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic                long_done, long_done_nxt;
   logic                level_nxt, mode_nxt;
   logic                press_nxt, release_nxt, long_nxt;

   // Input synchroniser; resets to the released pin level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{INV}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1] ^ INV;

   // State, timers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         long_done     <= 1'b0;
         btn_level     <= 1'b0;
         mode          <= MODE_INIT;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
      end else begin
         state         <= state_nxt;
         deb_cnt       <= deb_nxt;
         hold_cnt      <= hold_nxt;
         long_done     <= long_done_nxt;
         btn_level     <= level_nxt;
         mode          <= mode_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt     = state;
      deb_nxt       = deb_cnt;
      hold_nxt      = hold_cnt;
      long_done_nxt = long_done;
      level_nxt     = btn_level;
      mode_nxt      = mode;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (s) begin
               deb_nxt   = DEB_LOAD;
               state_nxt = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_nxt = IDLE;
            end else if (deb_cnt == '0) begin
               state_nxt     = PRESSED;
               level_nxt     = 1'b1;
               press_nxt     = 1'b1;
               mode_nxt      = ~mode;
               hold_nxt      = HOLD_LOAD;
               long_done_nxt = 1'b0;
            end else begin
               deb_nxt = deb_cnt - DEB_ONE;
            end
         end
         PRESSED: begin
            if (hold_cnt != '0) begin
               hold_nxt = hold_cnt - HOLD_ONE;
            end
            // long_done keeps a saturated timer from re-firing.
            if (hold_cnt == HOLD_ONE && !long_done) begin
               long_nxt      = 1'b1;
               long_done_nxt = 1'b1;
            end
            if (!s) begin
               deb_nxt   = DEB_LOAD;
               state_nxt = RELEASE_WAIT;
            end
         end
         RELEASE_WAIT: begin
            // Hold timer is frozen here so a glitch only delays long-press.
            if (s) begin
               state_nxt = PRESSED;
            end else if (deb_cnt == '0) begin
               state_nxt   = IDLE;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
            end else begin
               deb_nxt = deb_cnt - DEB_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: an active-high instance and an
// active-low instance with inverted mode reset value.
module tb_btn_conditioner;

   logic clk;
   logic rst;
   logic raw_a, raw_b;
   logic level_a, press_a, rel_a, long_a, mode_a;
   logic level_b, press_b, rel_b, long_b, mode_b;

   int total, bad;
   int cyc;
   int n_press, n_rel, n_long, n_multi;
   int t_press, t_rel, t_long;
   int nb_press, tb_press;
   int e0, e1, t_p0;

   btn_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
      .ACTIVE_LOW(0), .TOGGLE_INIT(0)
   ) dut_a (
      .clk(clk), .rst(rst), .btn_raw(raw_a),
      .btn_level(level_a), .press_pulse(press_a), .release_pulse(rel_a),
      .long_pulse(long_a), .mode(mode_a)
   );

   btn_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
      .ACTIVE_LOW(1), .TOGGLE_INIT(1)
   ) dut_b (
      .clk(clk), .rst(rst), .btn_raw(raw_b),
      .btn_level(level_b), .press_pulse(press_b), .release_pulse(rel_b),
      .long_pulse(long_b), .mode(mode_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      n_press = 0; n_rel = 0; n_long = 0;
      t_press = -1000; t_rel = -1000; t_long = -1000;
      nb_press = 0; tb_press = -1000;
   endtask

   // Advance n rising edges, sampling 1 time unit after each edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (press_a) begin n_press++; t_press = cyc; end
         if (rel_a)   begin n_rel++;   t_rel   = cyc; end
         if (long_a)  begin n_long++;  t_long  = cyc; end
         if ((32'(press_a) + 32'(rel_a) + 32'(long_a)) > 1) n_multi++;
         if (press_b) begin nb_press++; tb_press = cyc; end
      end
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; n_multi = 0;
      clr_stats();
      rst = 1'b1; raw_a = 1'b0; raw_b = 1'b1;
      step(3);
      rst = 1'b0;

      // Reset values
      chk("rst_level", 32'(level_a), 0);
      chk("rst_press", 32'(press_a), 0);
      chk("rst_rel",   32'(rel_a), 0);
      chk("rst_long",  32'(long_a), 0);
      chk("rst_mode",  32'(mode_a), 0);
      chk("rst_mode_b", 32'(mode_b), 1);
      chk("rst_level_b", 32'(level_b), 0);
      step(3);

      // Clean press held 10 cycles, then release
      clr_stats();
      e0 = cyc + 1; raw_a = 1'b1; step(10);
      chk("clean_npress", n_press, 1);
      chk("clean_tpress", t_press - e0, 6);
      chk("clean_mode",   32'(mode_a), 1);
      chk("clean_level",  32'(level_a), 1);
      e0 = cyc + 1; raw_a = 1'b0; step(12);
      chk("clean_nrel",  n_rel, 1);
      chk("clean_trel",  t_rel - e0, 6);
      chk("clean_nlong", n_long, 0);
      chk("clean_level0", 32'(level_a), 0);

      // Bounce: 3 high, 1 low, 10 high
      clr_stats();
      raw_a = 1'b1; step(3);
      raw_a = 1'b0; step(1);
      e1 = cyc + 1; raw_a = 1'b1; step(10);
      chk("bounce_npress", n_press, 1);
      chk("bounce_tpress", t_press - e1, 6);
      chk("bounce_mode",   32'(mode_a), 0);
      raw_a = 1'b0; step(12);
      chk("bounce_nrel", n_rel, 1);

      // Long press held 40 cycles
      clr_stats();
      raw_a = 1'b1; step(40);
      chk("long_nlong", n_long, 1);
      chk("long_delay", t_long - t_press, 20);
      chk("long_level_held", 32'(level_a), 1);
      e0 = cyc + 1; raw_a = 1'b0; step(5);
      chk("long_level_rdeb", 32'(level_a), 1);
      step(7);
      chk("long_level_rel", 32'(level_a), 0);
      chk("long_trel", t_rel - e0, 6);
      chk("long_nlong_end", n_long, 1);
      chk("long_mode", 32'(mode_a), 1);

      // Reset on the edge that would have produced press_pulse
      clr_stats();
      raw_a = 1'b1; step(6);
      rst = 1'b1; step(1);
      chk("mrst_press", 32'(press_a), 0);
      chk("mrst_level", 32'(level_a), 0);
      chk("mrst_mode",  32'(mode_a), 0);
      rst = 1'b0; raw_a = 1'b0; step(10);
      chk("mrst_npress", n_press, 0);
      chk("mrst_level_after", 32'(level_a), 0);

      // Release glitch: 10 high, 2 low, 40 high
      clr_stats();
      raw_a = 1'b1; step(10);
      t_p0 = t_press;
      raw_a = 1'b0; step(2);
      raw_a = 1'b1; step(40);
      chk("glitch_npress", n_press, 1);
      chk("glitch_nrel",   n_rel, 0);
      chk("glitch_nlong",  n_long, 1);
      chk("glitch_delay",  t_long - t_p0, 22);
      chk("glitch_level",  32'(level_a), 1);
      raw_a = 1'b0; step(12);
      chk("glitch_nrel_end", n_rel, 1);

      // Active-low instance with mode reset to 1
      clr_stats();
      e0 = cyc + 1; raw_b = 1'b0; step(10);
      chk("al_npress", nb_press, 1);
      chk("al_tpress", tb_press - e0, 6);
      chk("al_mode",   32'(mode_b), 0);
      chk("al_level",  32'(level_b), 1);

      chk("no_overlap", n_multi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
